// File: rtl/fd_circle_buf.sv
// fd_circle_buf: FAST-9 circle buffer.
// Collects one reference pixel (slot 0) and NUM_ADJ ring pixels (slots 1..NUM_ADJ), written one
// per cycle in any order. Once every slot is filled, the circle and a snapshot of the threshold
// register are moved into output registers and offered on a valid/ready handshake.
//
// Optional feature macro: FD_CIRCLE_DOUBLE_BUF_EN
//   defined   - filling continues while a circle is presented; a completed fill waits in the
//               bank until the presented circle is consumed, then transfers back-to-back.
//   undefined - writes are refused while a circle is presented.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   wrEn/regAddr/sramData slot write request, address and data
//   wrReady               a write is accepted this cycle
//   thresWe/thresIn       threshold register write
//   outValid/outReady     circle handshake
//   refPixel/adjPixel     presented circle (slot 1 in the adjPixel MSBs)
//   thres                 threshold snapshot taken with the circle
//   errAddr               sticky: a write used an address above NUM_ADJ
module fd_circle_buf #(
  parameter int unsigned PIXEL_W   = 8,
  parameter int unsigned NUM_ADJ   = 16,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned THRES_RST = 30
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wrEn,
  input  logic [ADDR_W-1:0]          regAddr,
  input  logic [PIXEL_W-1:0]         sramData,
  output logic                       wrReady,
  input  logic                       thresWe,
  input  logic [PIXEL_W-1:0]         thresIn,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [PIXEL_W-1:0]         refPixel,
  output logic [NUM_ADJ*PIXEL_W-1:0] adjPixel,
  output logic [PIXEL_W-1:0]         thres,
  output logic                       errAddr
);

  typedef enum logic [0:0] {StFill, StPresent} state_e;

  state_e                       r_state, w_state_d;
  logic [PIXEL_W-1:0]           r_bank [NUM_ADJ+1];
  logic [PIXEL_W-1:0]           w_bank_d [NUM_ADJ+1];
  logic [NUM_ADJ:0]             r_fill_mask, w_mask_d;
  logic [PIXEL_W-1:0]           r_thres_reg;
  logic [PIXEL_W-1:0]           r_ref;
  logic [NUM_ADJ*PIXEL_W-1:0]   r_adj, w_adj_d;
  logic [PIXEL_W-1:0]           r_thres_out;
  logic                         r_err;
  logic                         w_acc, w_legal, w_full_d, w_load;

  assign w_acc   = wrEn && wrReady;
  assign w_legal = (regAddr <= ADDR_W'(NUM_ADJ));

`ifdef FD_CIRCLE_DOUBLE_BUF_EN
  // Stall only when a completed fill is waiting behind an unconsumed circle.
  assign wrReady = !((&r_fill_mask) && (r_state == StPresent) && !outReady);
`else
  assign wrReady = (r_state == StFill);
`endif

  // Bank and fill mask including the write accepted at this edge; illegal addresses match no slot.
  always_comb begin
    w_bank_d = r_bank;
    w_mask_d = r_fill_mask;
    for (int i = 0; i <= int'(NUM_ADJ); i++) begin
      if (w_acc && (regAddr == ADDR_W'(i))) begin
        w_bank_d[i] = sramData;
        w_mask_d[i] = 1'b1;
      end
    end
  end

  assign w_full_d = &w_mask_d;

  always_comb begin
    w_adj_d = '0;
    for (int i = 1; i <= int'(NUM_ADJ); i++) begin
      w_adj_d[(int'(NUM_ADJ) - i)*int'(PIXEL_W) +: PIXEL_W] = w_bank_d[i];
    end
  end

  // w_load: move the completed bank into the output registers at this edge.
  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    unique case (r_state)
      StFill: begin
        if (w_full_d) begin
          w_load    = 1'b1;
          w_state_d = StPresent;
        end
      end
      StPresent: begin
        if (outReady) begin
`ifdef FD_CIRCLE_DOUBLE_BUF_EN
          if (w_full_d) begin
            w_load = 1'b1;
          end else begin
            w_state_d = StFill;
          end
`else
          w_state_d = StFill;
`endif
        end
      end
      default: w_state_d = StFill;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= int'(NUM_ADJ); i++) begin
        r_bank[i] <= '0;
      end
      r_fill_mask <= '0;
    end else begin
      r_bank      <= w_bank_d;
      r_fill_mask <= w_load ? '0 : w_mask_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_thres_reg <= PIXEL_W'(THRES_RST);
      r_ref       <= '0;
      r_adj       <= '0;
      r_thres_out <= PIXEL_W'(THRES_RST);
      r_err       <= 1'b0;
    end else begin
      if (thresWe) begin
        r_thres_reg <= thresIn;
      end
      // Snapshot uses the pre-edge register so a coincident threshold write hits the next circle.
      if (w_load) begin
        r_ref       <= w_bank_d[0];
        r_adj       <= w_adj_d;
        r_thres_out <= r_thres_reg;
      end
      if (w_acc && !w_legal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outValid = (r_state == StPresent);
  assign refPixel = r_ref;
  assign adjPixel = r_adj;
  assign thres    = r_thres_out;
  assign errAddr  = r_err;

endmodule

// File: tb/tb_fd_circle_buf.sv
// Directed testbench for fd_circle_buf (default parameters).
module tb_fd_circle_buf;

  logic         clock;
  logic         reset;
  logic         wrEn;
  logic [4:0]   regAddr;
  logic [7:0]   sramData;
  logic         wrReady;
  logic         thresWe;
  logic [7:0]   thresIn;
  logic         outValid;
  logic         outReady;
  logic [7:0]   refPixel;
  logic [127:0] adjPixel;
  logic [7:0]   thres;
  logic         errAddr;

  int vecs = 0;
  int errs = 0;

  fd_circle_buf #(
    .PIXEL_W  (8),
    .NUM_ADJ  (16),
    .ADDR_W   (5),
    .THRES_RST(30)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .wrEn    (wrEn),
    .regAddr (regAddr),
    .sramData(sramData),
    .wrReady (wrReady),
    .thresWe (thresWe),
    .thresIn (thresIn),
    .outValid(outValid),
    .outReady(outReady),
    .refPixel(refPixel),
    .adjPixel(adjPixel),
    .thres   (thres),
    .errAddr (errAddr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One write cycle; returns 1 time unit after the edge.
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    regAddr  = a;
    sramData = d;
    wrEn     = 1'b1;
    @(posedge clock);
    #1;
    wrEn = 1'b0;
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle();
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL rst_outValid got %0h want 0", outValid); end
    vecs++; if (wrReady !== 1'b1) begin errs++; $display("FAIL rst_wrReady got %0h want 1", wrReady); end
    vecs++; if (errAddr !== 1'b0) begin errs++; $display("FAIL rst_errAddr got %0h want 0", errAddr); end
    vecs++; if (refPixel !== 8'h00) begin errs++; $display("FAIL rst_refPixel got %0h want 0", refPixel); end
    vecs++; if (adjPixel !== 128'h0) begin errs++; $display("FAIL rst_adjPixel got %0h want 0", adjPixel); end
    vecs++; if (thres !== 8'd30) begin errs++; $display("FAIL rst_thres got %0h want 1e", thres); end
  endtask

  task automatic test_sequential();
    outReady = 1'b1;
    for (int a = 0; a < 17; a++) begin
      wr(5'(a), 8'h10 + 8'(a));
      if (a < 16) begin
        vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL seq_early_valid addr %0d got %0h want 0", a, outValid); end
      end
    end
    vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL seq_valid got %0h want 1", outValid); end
    vecs++; if (refPixel !== 8'h10) begin errs++; $display("FAIL seq_ref got %0h want 10", refPixel); end
    vecs++; if (adjPixel[127:120] !== 8'h11) begin errs++; $display("FAIL seq_slot1 got %0h want 11", adjPixel[127:120]); end
    vecs++; if (adjPixel[7:0] !== 8'h20) begin errs++; $display("FAIL seq_slot16 got %0h want 20", adjPixel[7:0]); end
    vecs++; if (thres !== 8'd30) begin errs++; $display("FAIL seq_thres got %0h want 1e", thres); end
`ifndef FD_CIRCLE_DOUBLE_BUF_EN
    vecs++; if (wrReady !== 1'b0) begin errs++; $display("FAIL seq_wrReady_busy got %0h want 0", wrReady); end
`endif
    idle();
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL seq_consumed got %0h want 0", outValid); end
    vecs++; if (refPixel !== 8'h10) begin errs++; $display("FAIL seq_hold_ref got %0h want 10", refPixel); end
    vecs++; if (wrReady !== 1'b1) begin errs++; $display("FAIL seq_wrReady_back got %0h want 1", wrReady); end
  endtask

  task automatic test_out_of_order();
    outReady = 1'b1;
    for (int a = 16; a >= 1; a--) begin
      wr(5'(a), 8'h30 + 8'(a));
    end
    wr(5'd5, 8'hAA);
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL ooo_early_valid got %0h want 0", outValid); end
    wr(5'd0, 8'h30);
    vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL ooo_valid got %0h want 1", outValid); end
    vecs++; if (adjPixel[95:88] !== 8'hAA) begin errs++; $display("FAIL ooo_slot5 got %0h want aa", adjPixel[95:88]); end
    vecs++; if (adjPixel[7:0] !== 8'h40) begin errs++; $display("FAIL ooo_slot16 got %0h want 40", adjPixel[7:0]); end
    vecs++; if (adjPixel[127:120] !== 8'h31) begin errs++; $display("FAIL ooo_slot1 got %0h want 31", adjPixel[127:120]); end
    vecs++; if (refPixel !== 8'h30) begin errs++; $display("FAIL ooo_ref got %0h want 30", refPixel); end
    idle();
  endtask

  task automatic test_illegal();
    outReady = 1'b1;
    vecs++; if (errAddr !== 1'b0) begin errs++; $display("FAIL ill_err_before got %0h want 0", errAddr); end
    wr(5'd20, 8'h99);
    vecs++; if (errAddr !== 1'b1) begin errs++; $display("FAIL ill_err_set got %0h want 1", errAddr); end
    for (int a = 0; a < 16; a++) begin
      wr(5'(a), 8'h50 + 8'(a));
      vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL ill_early_valid addr %0d got %0h want 0", a, outValid); end
    end
    wr(5'd16, 8'h60);
    vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL ill_valid got %0h want 1", outValid); end
    vecs++; if (refPixel !== 8'h50) begin errs++; $display("FAIL ill_ref got %0h want 50", refPixel); end
    idle();
    idle();
    vecs++; if (errAddr !== 1'b1) begin errs++; $display("FAIL ill_err_sticky got %0h want 1", errAddr); end
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    for (int a = 0; a < 17; a++) begin
      wr(5'(a), 8'h60 + 8'(a));
    end
    vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL bp_valid got %0h want 1", outValid); end
`ifndef FD_CIRCLE_DOUBLE_BUF_EN
    for (int c = 0; c < 10; c++) begin
      regAddr  = 5'd0;
      sramData = 8'hEE;
      wrEn     = 1'b1;
      idle();
      vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL bp_hold_valid cyc %0d got %0h want 1", c, outValid); end
      vecs++; if (wrReady !== 1'b0) begin errs++; $display("FAIL bp_wrReady cyc %0d got %0h want 0", c, wrReady); end
      vecs++; if (refPixel !== 8'h60) begin errs++; $display("FAIL bp_ref cyc %0d got %0h want 60", c, refPixel); end
      vecs++; if (adjPixel[7:0] !== 8'h70) begin errs++; $display("FAIL bp_slot16 cyc %0d got %0h want 70", c, adjPixel[7:0]); end
    end
    wrEn     = 1'b0;
    outReady = 1'b1;
    idle();
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL bp_consumed got %0h want 0", outValid); end
    // Slot 0 last: a write leaked during backpressure would complete the circle early.
    for (int a = 1; a < 17; a++) begin
      wr(5'(a), 8'h80 + 8'(a));
    end
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL bp_leak got %0h want 0", outValid); end
    wr(5'd0, 8'h80);
    vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL bp_second_valid got %0h want 1", outValid); end
    vecs++; if (refPixel !== 8'h80) begin errs++; $display("FAIL bp_second_ref got %0h want 80", refPixel); end
    vecs++; if (adjPixel[7:0] !== 8'h90) begin errs++; $display("FAIL bp_second_slot16 got %0h want 90", adjPixel[7:0]); end
    idle();
`else
    for (int a = 0; a < 17; a++) begin
      wr(5'(a), 8'h80 + 8'(a));
      vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL bp_hold_valid addr %0d got %0h want 1", a, outValid); end
      vecs++; if (refPixel !== 8'h60) begin errs++; $display("FAIL bp_ref addr %0d got %0h want 60", a, refPixel); end
    end
    vecs++; if (wrReady !== 1'b0) begin errs++; $display("FAIL bp_wrReady_full got %0h want 0", wrReady); end
    repeat (3) idle();
    vecs++; if (adjPixel[7:0] !== 8'h70) begin errs++; $display("FAIL bp_slot16 got %0h want 70", adjPixel[7:0]); end
    outReady = 1'b1;
    idle();
    vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL bp_b2b_valid got %0h want 1", outValid); end
    vecs++; if (refPixel !== 8'h80) begin errs++; $display("FAIL bp_second_ref got %0h want 80", refPixel); end
    vecs++; if (adjPixel[7:0] !== 8'h90) begin errs++; $display("FAIL bp_second_slot16 got %0h want 90", adjPixel[7:0]); end
    idle();
`endif
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL bp_final_consumed got %0h want 0", outValid); end
  endtask

  task automatic test_thres_at_completion();
    outReady = 1'b1;
    for (int a = 0; a < 16; a++) begin
      wr(5'(a), 8'hA0 + 8'(a));
    end
    thresWe = 1'b1;
    thresIn = 8'h40;
    wr(5'd16, 8'hB0);
    thresWe = 1'b0;
    vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL thr_valid got %0h want 1", outValid); end
    vecs++; if (thres !== 8'd30) begin errs++; $display("FAIL thr_first got %0h want 1e", thres); end
    idle();
    for (int a = 0; a < 17; a++) begin
      wr(5'(a), 8'hA0 + 8'(a));
    end
    vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL thr_valid2 got %0h want 1", outValid); end
    vecs++; if (thres !== 8'h40) begin errs++; $display("FAIL thr_second got %0h want 40", thres); end
    idle();
  endtask

  task automatic test_reset_mid();
    outReady = 1'b1;
    for (int a = 0; a < 9; a++) begin
      wr(5'(a), 8'hC0 + 8'(a));
    end
    reset = 1'b1;
    #3;
    // Asynchronous: outputs clear before any clock edge.
    vecs++; if (errAddr !== 1'b0) begin errs++; $display("FAIL rm_err_clr got %0h want 0", errAddr); end
    vecs++; if (refPixel !== 8'h00) begin errs++; $display("FAIL rm_ref_clr got %0h want 0", refPixel); end
    vecs++; if (thres !== 8'd30) begin errs++; $display("FAIL rm_thres_clr got %0h want 1e", thres); end
    reset = 1'b0;
    idle();
    for (int a = 9; a < 17; a++) begin
      wr(5'(a), 8'hD0 + 8'(a));
    end
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL rm_stale_fill got %0h want 0", outValid); end
    for (int a = 0; a < 9; a++) begin
      wr(5'(a), 8'hD0 + 8'(a));
      if (a < 8) begin
        vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL rm_early addr %0d got %0h want 0", a, outValid); end
      end
    end
    vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL rm_valid got %0h want 1", outValid); end
    vecs++; if (refPixel !== 8'hD0) begin errs++; $display("FAIL rm_ref got %0h want d0", refPixel); end
    vecs++; if (adjPixel[127:120] !== 8'hD1) begin errs++; $display("FAIL rm_slot1 got %0h want d1", adjPixel[127:120]); end
    vecs++; if (adjPixel[7:0] !== 8'hE0) begin errs++; $display("FAIL rm_slot16 got %0h want e0", adjPixel[7:0]); end
    vecs++; if (thres !== 8'd30) begin errs++; $display("FAIL rm_thres got %0h want 1e", thres); end
    idle();
  endtask

  initial begin
    reset    = 1'b1;
    wrEn     = 1'b0;
    regAddr  = '0;
    sramData = '0;
    thresWe  = 1'b0;
    thresIn  = '0;
    outReady = 1'b0;
    test_reset();
    test_sequential();
    test_out_of_order();
    test_illegal();
    test_backpressure();
    test_thres_at_completion();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
